req_gnt_responder: RTL

REQ_GNT_RESPONDER -- requirements
Module: req_gnt_responder

---
 rtl/req_gnt_pkg.sv | 27 ++
 rtl/gnt_delay_ch.sv | 64 ++++++
 rtl/req_gnt_responder_sva.sv | 39 +++
 rtl/req_gnt_responder.sv | 77 +++++++
 4 files changed

// File: rtl/req_gnt_pkg.sv
// Shared definitions for the request/grant responder: ch1 delay limits,
// ch1 state encoding and small combinational helpers.
package req_gnt_pkg;

   localparam int         CNT_W_DEF   = 8;
   localparam logic [2:0] CH1_DLY_MIN = 3'd3;
   localparam logic [2:0] CH1_DLY_MAX = 3'd6;

   typedef enum logic {
      CH1_IDLE = 1'b0,
      CH1_WAIT = 1'b1
   } ch1_state_e;

   // Requested ch1 latency if legal, otherwise the configured fallback.
   function automatic logic [2:0] ch1_delay(input logic [2:0] dly, input logic [2:0] dly_def);
      if ((dly >= CH1_DLY_MIN) && (dly <= CH1_DLY_MAX)) begin
         return dly;
      end else begin
         return dly_def;
      end
   endfunction

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/gnt_delay_ch.sv
// Channel-1 grant engine: IDLE/WAIT FSM with a programmable countdown.
// A new request may be taken in the grant cycle itself, chaining grants.
module gnt_delay_ch import req_gnt_pkg::*; #(
   parameter logic [2:0] DLY_DEF = 3'd4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_i,
   input  logic [2:0] dly_i,
   output logic       gnt_o,
   output logic       busy_o,
   output logic       drop_o
);

   ch1_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       gnt_q, gnt_d;
   logic       accept_s;

   // Next-state logic; cnt_q reaches zero exactly in the grant cycle.
   always_comb begin
      accept_s = req_i && ((state_q == CH1_IDLE) || gnt_q);
      drop_o   = req_i && (state_q == CH1_WAIT) && !gnt_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      if (accept_s) begin
         state_d = CH1_WAIT;
         cnt_d   = ch1_delay(dly_i, DLY_DEF) - 3'd1;
      end else begin
         case (state_q)
            CH1_WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_d = CH1_IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = CH1_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
      gnt_d = (state_d == CH1_WAIT) && (cnt_d == 3'd0);
   end

   // State, countdown and grant registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= CH1_IDLE;
         cnt_q   <= 3'd0;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign busy_o = (state_q == CH1_WAIT);

endmodule

// File: rtl/req_gnt_responder_sva.sv
// Protocol checker for req_gnt_responder: grant latency per channel.
module req_gnt_responder_sva (
   input logic       clk,
   input logic       rst,
   input logic       en,
   input logic [2:0] req,
   input logic [2:0] gnt,
   input logic       ch1_busy
);

   logic       ch0_due_q;
   logic [2:0] wait_q;

   // Track ch0 due-grant and cycles elapsed since an idle ch1 acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch0_due_q <= 1'b0;
         wait_q    <= 3'd0;
      end else begin
         ch0_due_q <= req[0] && en;
         if (gnt[1]) begin
            wait_q <= (req[1] && en) ? 3'd1 : 3'd0;
         end else if (req[1] && en && !ch1_busy) begin
            wait_q <= 3'd1;
         end else if ((wait_q != 3'd0) && (wait_q != 3'd7)) begin
            wait_q <= wait_q + 3'd1;
         end else begin
            wait_q <= wait_q;
         end
      end
   end

   a_ch0_lat1: assert property (@(posedge clk) disable iff (rst) ch0_due_q |-> gnt[0]);
   a_ch1_late: assert property (@(posedge clk) disable iff (rst) (wait_q == 3'd6) |-> gnt[1]);
   a_ch1_early: assert property (@(posedge clk) disable iff (rst)
      gnt[1] |-> ((wait_q >= 3'd3) && (wait_q <= 3'd6)));
   a_ch2_lat0: assert property (@(posedge clk) disable iff (rst) (req[2] && en) |-> gnt[2]);

endmodule

// File: rtl/req_gnt_responder.sv
// Three-channel request/grant responder: ch0 latency 1, ch1 programmable
// latency via gnt_delay_ch, ch2 combinational, plus saturating statistics.
module req_gnt_responder import req_gnt_pkg::*; #(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int CH1_DLY_DEF = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       req,
   input  logic [2:0]       ch1_dly,
   output logic [2:0]       gnt,
   output logic             ch1_busy,
   output logic [CNT_W-1:0] ch1_drop_cnt,
   output logic [CNT_W-1:0] gnt_total
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             gnt0_q;
   logic             gnt1_s, busy1_s, drop1_s;
   logic [CNT_W-1:0] drop_cnt_q, gnt_total_q;
   logic [CNT_W+1:0] total_sum_s;

   gnt_delay_ch #(
      .DLY_DEF(3'(CH1_DLY_DEF))
   ) u_ch1 (
      .clk_i (clk),
      .rst_i (rst),
      .req_i (req[1] && en),
      .dly_i (ch1_dly),
      .gnt_o (gnt1_s),
      .busy_o(busy1_s),
      .drop_o(drop1_s)
   );

   // Outputs are forced low during reset, before the registers clear.
   always_comb begin
      gnt         = {req[2] && en && !rst, gnt1_s && !rst, gnt0_q && !rst};
      ch1_busy    = busy1_s && !rst;
      total_sum_s = (CNT_W+2)'(gnt_total_q) + (CNT_W+2)'(popcount3(gnt));
   end

   // ch0 pipeline stage and saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0_q      <= 1'b0;
         drop_cnt_q  <= '0;
         gnt_total_q <= '0;
      end else begin
         gnt0_q <= req[0] && en;
         if (drop1_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         end else begin
            drop_cnt_q <= drop_cnt_q;
         end
         if (total_sum_s[CNT_W+1:CNT_W] != 2'b00) begin
            gnt_total_q <= CNT_MAX;
         end else begin
            gnt_total_q <= total_sum_s[CNT_W-1:0];
         end
      end
   end

   assign ch1_drop_cnt = drop_cnt_q;
   assign gnt_total    = gnt_total_q;

   req_gnt_responder_sva u_sva (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .ch1_busy(ch1_busy)
   );

endmodule
